hazard_fwd_unit: RTL

- Parametrised successor to the fixed three-stage data-hazard and nop logic in the control section.
- Keeps a scoreboard of in-flight destination registers over DEPTH pipeline stages.
- For each of NUM_SRC source operands, generates an encoded forwarding select, a load-use stall, and a multi-cycle branch flush.
- Sits beside the decode stage: decode drives its inputs, and the outputs steer the ALU operand muxes and the pipeline-register enables/clears.

---
 rtl/hazard_pkg.sv | 25 ++
 rtl/hazard_src_match.sv | 33 +++
 rtl/hazard_fwd_unit.sv | 94 +++++++++
 3 files changed

// File: rtl/hazard_pkg.sv
// Shared types for the hazard / forwarding unit: scoreboard entry layout,
// flush FSM states and the "no forwarding" select code.
package hazard_pkg;

  // The scoreboard stores register indices at this fixed width. Narrower
  // REG_W values are zero-extended into it, so REG_W must not exceed it.
  localparam int MAX_REG_W = 8;

  // Forwarding select value meaning "read the register file".
  localparam int SEL_REGFILE = 0;

  typedef struct packed {
    logic                 valid;
    logic [MAX_REG_W-1:0] rd;
    logic                 is_load;
  } sb_entry_t;

  typedef enum logic {
    IDLE  = 1'b0,
    FLUSH = 1'b1
  } flush_state_t;

  localparam sb_entry_t SB_EMPTY = '{valid: 1'b0, rd: '0, is_load: 1'b0};

endpackage

// File: rtl/hazard_src_match.sv
// Compares one source operand against every scoreboard stage. Returns the
// youngest matching stage as a select code, plus a flag for a match on a
// load that is still too young to forward.
module hazard_src_match
  import hazard_pkg::*;
#(
  parameter  int REG_W    = 5,
  parameter  int DEPTH    = 3,
  parameter  int LOAD_LAT = 1,
  localparam int SEL_W    = $clog2(DEPTH + 1)
) (
  input  logic      [REG_W-1:0] rs_i,
  input  sb_entry_t [DEPTH-1:0] sb_i,      // index 0 = stage 1 (execute)
  output logic      [SEL_W-1:0] sel_o,
  output logic                  load_hit_o
);

  // Scan from oldest to youngest so the youngest match is written last.
  always_comb begin
    // NOTE: defaults first so every path assigns both outputs; otherwise a latch is inferred.
    sel_o      = SEL_W'(SEL_REGFILE);
    load_hit_o = 1'b0;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      if (sb_i[k].valid && (sb_i[k].rd == MAX_REG_W'(rs_i)) && (rs_i != '0)) begin
        sel_o = SEL_W'(k + 1);
        if ((k < LOAD_LAT) && sb_i[k].is_load) begin
          load_hit_o = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/hazard_fwd_unit.sv
// Data-hazard unit beside decode: tracks in-flight destination registers
// over DEPTH producer stages, and from them drives per-operand forwarding
// selects, a load-use stall and a multi-cycle flush after a taken branch.
module hazard_fwd_unit
  import hazard_pkg::*;
#(
  parameter  int REG_W        = 5,
  parameter  int NUM_SRC      = 2,
  parameter  int DEPTH        = 3,
  parameter  int LOAD_LAT     = 1,
  parameter  int FLUSH_CYCLES = 2,
  localparam int SEL_W        = $clog2(DEPTH + 1)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     id_valid,
  input  logic [NUM_SRC*REG_W-1:0] id_rs,
  input  logic [REG_W-1:0]         id_rd,
  input  logic                     id_we,
  input  logic                     id_is_load,
  input  logic                     br_taken,
  output logic [NUM_SRC*SEL_W-1:0] fwd_sel,
  output logic                     stall,
  output logic                     flush
);

  localparam int CNT_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

  sb_entry_t [DEPTH-1:0]         sb_q, sb_d;
  flush_state_t                  state_q;
  logic [CNT_W-1:0]              cnt_q;
  logic [NUM_SRC-1:0]            load_hit;
  logic [NUM_SRC*SEL_W-1:0]      sel_raw;

  for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_src
    hazard_src_match #(
      .REG_W   (REG_W),
      .DEPTH   (DEPTH),
      .LOAD_LAT(LOAD_LAT)
    ) u_match (
      .rs_i      (id_rs[gi*REG_W +: REG_W]),
      .sb_i      (sb_q),
      .sel_o     (sel_raw[gi*SEL_W +: SEL_W]),
      .load_hit_o(load_hit[gi])
    );
  end

  // Flush covers the branch cycle itself plus any remaining FLUSH cycles;
  // it overrides stall so a killed instruction never holds the pipe.
  assign flush   = br_taken | (state_q == FLUSH);
  assign stall   = id_valid & (|load_hit) & ~flush;
  assign fwd_sel = id_valid ? sel_raw : '0;

  // Next scoreboard: age every entry by one stage, admit decode into stage 1.
  always_comb begin
    sb_d[0] = SB_EMPTY;
    for (int k = 1; k < DEPTH; k++) begin
      sb_d[k] = sb_q[k-1];
    end
    if (id_valid && id_we && (id_rd != '0) && !stall && !flush) begin
      sb_d[0] = '{valid: 1'b1, rd: MAX_REG_W'(id_rd), is_load: id_is_load};
    end
  end

  // Scoreboard shift register.
  // NOTE: non-blocking assignments so every stage samples its pre-edge neighbour.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: this storage is reset on purpose; a stale valid bit would forward a dead value.
      sb_q <= '0;
    end else begin
      sb_q <= sb_d;
    end
  end

  // Flush FSM. The counter holds the FLUSH cycles still owed, including the
  // current one; the branch cycle itself is covered by br_taken, so an
  // isolated branch yields FLUSH_CYCLES flush cycles in total.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else if (br_taken) begin
      cnt_q   <= CNT_W'(FLUSH_CYCLES - 1);
      state_q <= (FLUSH_CYCLES > 1) ? FLUSH : IDLE;
    end else if (state_q == FLUSH) begin
      cnt_q <= cnt_q - CNT_W'(1);
      if (cnt_q == CNT_W'(1)) begin
        state_q <= IDLE;
      end
    end
  end

endmodule
